// File: rtl/spi_ctrl_master.sv
// spi_ctrl_master: SPI mode-0 frame controller (16-bit R/W+addr+data); optional readback via SPI_CTRL_READ_EN
module spi_ctrl_master #(
  parameter int HALF_DIV = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       busy,
  output logic       done,
  output logic       sclk,
  output logic       copi,
`ifdef SPI_CTRL_READ_EN
  input  logic       cipo,
  output logic [7:0] rdata,
`endif
  output logic       ncs
);
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;
  state_t state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic [15:0] shreg, shreg_nx;
  logic [3:0] bit_idx, bit_idx_nx;
  logic [1:0] phase, phase_nx;
  logic sclk_nx, copi_nx, ncs_nx, done_nx, tick;
`ifdef SPI_CTRL_READ_EN
  logic [7:0] rx, rx_nx, rdata_nx;
`endif
  assign tick = cnt == 8'(HALF_DIV - 1);
  assign req_ready = state == IDLE;
  assign busy = state != IDLE;
  // Register all state and SPI pins; reset forces the bus idle immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      shreg <= '0;
      bit_idx <= '0;
      phase <= '0;
      sclk <= 1'b0;
      copi <= 1'b0;
      ncs <= 1'b1;
      done <= 1'b0;
`ifdef SPI_CTRL_READ_EN
      rx <= '0;
      rdata <= '0;
`endif
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      shreg <= shreg_nx;
      bit_idx <= bit_idx_nx;
      phase <= phase_nx;
      sclk <= sclk_nx;
      copi <= copi_nx;
      ncs <= ncs_nx;
      done <= done_nx;
`ifdef SPI_CTRL_READ_EN
      rx <= rx_nx;
      rdata <= rdata_nx;
`endif
    end
  end
  // Next-state: phase counts the two trailing low half-periods in SHIFT and the two gap half-periods
  always_comb begin
    state_nx = state;
    cnt_nx = (state == IDLE || tick) ? 8'd0 : cnt + 8'd1;
    shreg_nx = shreg;
    bit_idx_nx = bit_idx;
    phase_nx = phase;
    sclk_nx = sclk;
    copi_nx = copi;
    ncs_nx = ncs;
    done_nx = 1'b0;
`ifdef SPI_CTRL_READ_EN
    rx_nx = rx;
    rdata_nx = rdata;
`endif
    case (state)
      IDLE: if (req_valid) begin
        shreg_nx = {req_write, req_addr, req_wdata};
        copi_nx = req_write;
        ncs_nx = 1'b0;
        state_nx = SETUP;
      end
      SETUP: if (tick) begin
        sclk_nx = 1'b1;
        bit_idx_nx = 4'd15;
        phase_nx = 2'd0;
        state_nx = SHIFT;
      end
      SHIFT: if (tick) begin
        if (phase == 2'd2) begin
          ncs_nx = 1'b1;
          copi_nx = 1'b0;
          phase_nx = 2'd0;
          state_nx = GAP;
        end else if (phase == 2'd1) begin
          phase_nx = 2'd2;
        end else if (sclk) begin
          sclk_nx = 1'b0;
          if (bit_idx == 4'd0) phase_nx = 2'd1;
          else begin
            bit_idx_nx = bit_idx - 4'd1;
            copi_nx = shreg[bit_idx - 4'd1];
          end
        end else begin
          sclk_nx = 1'b1;
`ifdef SPI_CTRL_READ_EN
          if (!shreg[15] && bit_idx < 4'd8) rx_nx = {rx[6:0], cipo};
`endif
        end
      end
      GAP: if (tick) begin
        if (phase == 2'd1) begin
          done_nx = 1'b1;
          phase_nx = 2'd0;
          state_nx = IDLE;
`ifdef SPI_CTRL_READ_EN
          if (!shreg[15]) rdata_nx = rx;
`endif
        end else phase_nx = 2'd1;
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_spi_ctrl_master.sv
// tb_spi_ctrl_master: scoreboard bench for spi_ctrl_master with a mode-0 capture monitor and register model
module tb_spi_ctrl_master;
  localparam int HD = 4;
  logic clk = 0, rst_n = 0;
  logic req_valid = 0, req_write = 0;
  logic [6:0] req_addr = 0;
  logic [7:0] req_wdata = 0;
  logic req_ready, busy, done, sclk, copi, ncs;
`ifdef SPI_CTRL_READ_EN
  logic cipo = 0;
  logic [7:0] rdata;
  logic [15:0] cipo_pat = 0;
  int nf = 0;
`endif
  spi_ctrl_master #(.HALF_DIV(HD)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .done(done), .sclk(sclk), .copi(copi),
`ifdef SPI_CTRL_READ_EN
    .cipo(cipo), .rdata(rdata),
`endif
    .ncs(ncs));
  always #5 clk = ~clk;
  typedef struct {logic [15:0] frame; int rises; int low; int viol; int t_end;} frame_t;
  frame_t got_q[$];
  logic [15:0] exp_q[$];
  int done_t[$];
  int checks = 0, failures = 0, cyc = 0, acc_t = 0;
  logic [7:0] regs [128];
  logic [15:0] m_fr = 0;
  int m_rises = 0, m_low = 0, m_viol = 0;
  logic p_ncs = 1, p_sclk = 0, p_copi = 0;
  always @(posedge clk) cyc <= cyc + 1;
  // Monitor: capture copi on sclk rising edges, measure ncs low time, log done pulses
  always @(negedge clk) begin
    if (!ncs && p_ncs) begin
      m_fr = 0; m_rises = 0; m_low = 0; m_viol = 0;
`ifdef SPI_CTRL_READ_EN
      nf = 0; cipo = cipo_pat[15];
`endif
    end
    if (!ncs) m_low++;
    if (!ncs && sclk && !p_sclk) begin
      m_fr = {m_fr[14:0], copi};
      m_rises++;
      if (copi !== p_copi) m_viol++;
    end
`ifdef SPI_CTRL_READ_EN
    if (!ncs && !sclk && p_sclk) begin
      nf++;
      if (nf < 16) cipo = cipo_pat[15 - nf];
    end
`endif
    if (ncs && !p_ncs) got_q.push_back('{m_fr, m_rises, m_low, m_viol, cyc});
    if (done) done_t.push_back(cyc);
    p_ncs = ncs; p_sclk = sclk; p_copi = copi;
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  task automatic send(input logic w, input logic [6:0] a, input logic [7:0] d);
    int k = 0;
    @(negedge clk);
    req_write = w; req_addr = a; req_wdata = d; req_valid = 1;
    while (!req_ready && k < 1000) begin @(negedge clk); k++; end
    checks++;
    if (!req_ready) begin failures++; $display("FAIL accept_timeout got=0 want=1"); end
    @(posedge clk); #1;
    acc_t = cyc;
    exp_q.push_back({w, a, d});
    req_valid = 0; req_write = ~w; req_addr = ~a; req_wdata = ~d;
  endtask
  task automatic wait_for(input int n_got, input int n_done);
    int k = 0;
    while ((got_q.size() < n_got || done_t.size() < n_done) && k < 2000) begin @(negedge clk); k++; end
    checks++;
    if (got_q.size() < n_got || done_t.size() < n_done) begin
      failures++;
      $display("FAIL wait_timeout frames=%0d/%0d dones=%0d/%0d", got_q.size(), n_got, done_t.size(), n_done);
    end
  endtask
  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({sclk, copi, ncs, busy, done, req_ready} !== 6'b001001) begin
      failures++; $display("FAIL reset_outputs got=%b want=001001", {sclk, copi, ncs, busy, done, req_ready});
    end
`ifdef SPI_CTRL_READ_EN
    checks++;
    if (rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h want=00", rdata); end
`endif
    rst_n = 1;
    @(negedge clk);
  endtask
  task automatic test_write_basic();
    frame_t f;
    logic [15:0] e;
    send(1'b1, 7'h00, 8'hF0);
    wait_for(1, 1);
    if (got_q.size() > 0 && exp_q.size() > 0 && done_t.size() > 0) begin
      f = got_q.pop_front(); e = exp_q.pop_front();
      checks += 5;
      if (f.frame !== e) begin failures++; $display("FAIL basic_frame got=%h want=%h", f.frame, e); end
      if (f.rises != 16) begin failures++; $display("FAIL basic_rises got=%0d want=16", f.rises); end
      if (f.low != 34 * HD) begin failures++; $display("FAIL basic_ncs_low got=%0d want=%0d", f.low, 34 * HD); end
      if (f.viol != 0) begin failures++; $display("FAIL basic_copi_stable got=%0d want=0", f.viol); end
      if (done_t[0] - f.t_end != 2 * HD) begin failures++; $display("FAIL basic_done_delay got=%0d want=%0d", done_t[0] - f.t_end, 2 * HD); end
      void'(done_t.pop_front());
    end
    repeat (20) @(negedge clk);
    checks += 2;
    if (done_t.size() != 0) begin failures++; $display("FAIL basic_single_done got=%0d want=0", done_t.size()); end
    if ({busy, req_ready} !== 2'b01) begin failures++; $display("FAIL basic_idle got=%b want=01", {busy, req_ready}); end
  endtask
  task automatic test_loopback();
    frame_t f;
    logic [15:0] e;
    foreach (regs[i]) regs[i] = 8'h00;
    send(1'b1, 7'h02, 8'hFF);
    send(1'b1, 7'h04, 8'h80);
    wait_for(2, 2);
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      f = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (f.frame !== e) begin failures++; $display("FAIL loop_frame got=%h want=%h", f.frame, e); end
      if (f.frame[15]) regs[f.frame[14:8]] = f.frame[7:0];
    end
    done_t.delete();
    checks += 2;
    if (regs[2] !== 8'hFF) begin failures++; $display("FAIL loop_en_pwm got=%h want=ff", regs[2]); end
    if (regs[4] !== 8'h80) begin failures++; $display("FAIL loop_duty got=%h want=80", regs[4]); end
  endtask
  task automatic test_back_to_back();
    logic [15:0] vals [3] = '{16'hA1C3, 16'h8A5A, 16'h7F01};
    int acc [3];
    frame_t f;
    logic [15:0] e;
    @(negedge clk);
    req_valid = 1;
    for (int i = 0; i < 3; i++) begin
      int k = 0;
      {req_write, req_addr, req_wdata} = vals[i];
      while (!req_ready && k < 1000) begin @(negedge clk); k++; end
      @(posedge clk); #1;
      acc[i] = cyc;
      exp_q.push_back(vals[i]);
      req_addr = 7'h55; req_wdata = 8'hC3;
      repeat (40) @(negedge clk);
    end
    req_valid = 0;
    wait_for(3, 3);
    checks += 2;
    if (acc[1] - acc[0] != 36 * HD + 1) begin failures++; $display("FAIL b2b_spacing01 got=%0d want=%0d", acc[1] - acc[0], 36 * HD + 1); end
    if (acc[2] - acc[1] != 36 * HD + 1) begin failures++; $display("FAIL b2b_spacing12 got=%0d want=%0d", acc[2] - acc[1], 36 * HD + 1); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      f = got_q.pop_front(); e = exp_q.pop_front();
      checks += 2;
      if (f.frame !== e) begin failures++; $display("FAIL b2b_frame got=%h want=%h", f.frame, e); end
      if (f.low != 34 * HD) begin failures++; $display("FAIL b2b_ncs_low got=%0d want=%0d", f.low, 34 * HD); end
    end
    done_t.delete();
  endtask
  task automatic test_reset_midframe();
    int k = 0;
    send(1'b1, 7'h11, 8'h22);
    while (m_rises < 9 && k < 1000) begin @(negedge clk); k++; end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({ncs, sclk} !== 2'b10) begin failures++; $display("FAIL rst_mid_pins got=%b want=10", {ncs, sclk}); end
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (4 * HD * 10) @(negedge clk);
    checks += 2;
    if (done_t.size() != 0) begin failures++; $display("FAIL rst_mid_done got=%0d want=0", done_t.size()); end
    if ({req_ready, busy, ncs} !== 3'b101) begin failures++; $display("FAIL rst_mid_idle got=%b want=101", {req_ready, busy, ncs}); end
    got_q.delete(); exp_q.delete(); done_t.delete();
  endtask
`ifdef SPI_CTRL_READ_EN
  task automatic test_read();
    frame_t f;
    cipo_pat = 16'h00A5;
    send(1'b0, 7'h03, 8'h3C);
    wait_for(1, 1);
    checks++;
    if (rdata !== 8'hA5) begin failures++; $display("FAIL read_rdata got=%h want=a5", rdata); end
    if (got_q.size() > 0 && exp_q.size() > 0) begin
      f = got_q.pop_front();
      checks++;
      if (f.frame !== exp_q[0]) begin failures++; $display("FAIL read_frame got=%h want=%h", f.frame, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    done_t.delete();
    cipo_pat = 16'h005A;
    send(1'b1, 7'h04, 8'h11);
    wait_for(1, 1);
    checks++;
    if (rdata !== 8'hA5) begin failures++; $display("FAIL write_keeps_rdata got=%h want=a5", rdata); end
    got_q.delete(); exp_q.delete(); done_t.delete();
  endtask
`endif
  initial begin
    test_reset();
    test_write_basic();
    test_loopback();
    test_back_to_back();
    test_reset_midframe();
`ifdef SPI_CTRL_READ_EN
    test_read();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
